// File: rtl/uart_txrx_param.sv
// ----------------------------------------------------------------------------
// uart_txrx_param
//   Parametrised full-duplex UART core on a single clock domain. A shared
//   free-running divider produces one-clk ticks at BAUD*OVERSAMPLE. The TX
//   path serialises words accepted on a valid/ready port. The RX path
//   synchronises rxd, qualifies the start bit at mid-bit and samples every
//   bit at mid-bit. It emits one-clk pulses for valid data, framing errors
//   and parity errors.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : one parity bit (^data ^ PARITY_ODD) follows the data bits
//               in both directions, and rx_parity_err is driven.
//   undefined : no parity bit, PARITY_ODD is ignored, rx_parity_err stays 0.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   tx_data        word to send (DATA_BITS)
//   tx_valid       tx_data valid; accepted when tx_ready is high
//   tx_ready       TX idle, can accept a word
//   tx_busy        frame in flight (~tx_ready)
//   txd            serial out, idle high
//   rxd            serial in, asynchronous to clk
//   rx_data        last good received word, held until the next rx_valid
//   rx_valid       1-clk pulse, new rx_data
//   rx_frame_err   1-clk pulse, stop bit sampled low
//   rx_parity_err  1-clk pulse alongside rx_valid on a parity mismatch
// ----------------------------------------------------------------------------
module uart_txrx_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Rounded divider, never below one clk per tick.
    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] OS_HALF   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    // ---------------- state ----------------
    logic [CNT_W-1:0]     div_q, div_d;
    logic                 tick;

    tx_state_t            tx_state_q, tx_state_d;
    logic [TICK_W-1:0]    tx_tick_q, tx_tick_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;

    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    rx_state_t            rx_state_q, rx_state_d;
    logic [TICK_W-1:0]    rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;

    logic                 tx_bit_end;
    logic                 rx_bit_end;
    logic                 rx_half_end;

    // ---------------- tick generator ----------------
    assign tick = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        div_d = tick ? '0 : div_q + CNT_W'(1);
    end

    // ---------------- TX next state ----------------
    assign tx_bit_end = tick && (tx_tick_q == OS_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;

        if (tick && tx_state_q != TX_IDLE) begin
            tx_tick_d = tx_bit_end ? '0 : tx_tick_q + TICK_W'(1);
        end

        case (tx_state_q)
            TX_IDLE: begin
                // tx_ready is exactly "in IDLE", so tx_valid alone means accept.
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PARITY_ODD[0];
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // txd is registered from the next state so the pin never glitches.
        case (tx_state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shift_d[0];
            TX_PARITY: txd_d = tx_par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    // ---------------- RX next state ----------------
    assign sync_d      = {sync_q[0], rxd};
    assign rx_s        = sync_q[1];
    assign rx_bit_end  = tick && (rx_tick_q == OS_LAST);
    assign rx_half_end = tick && (rx_tick_q == OS_HALF);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_perr_d  = 1'b0;

        if (tick) begin
            rx_tick_d = rx_bit_end ? '0 : rx_tick_q + TICK_W'(1);
        end

        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (!rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                // Re-check at mid start bit; a high line here was a glitch.
                if (rx_half_end) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_par_d   = rx_s;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rx_s) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_perr_d  = PAR_EN && ((^rx_shift_q) ^ PARITY_ODD[0] ^ rx_par_q);
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Hold off until the line recovers so a long low flags once.
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            div_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // ---------------- outputs ----------------
    assign tx_ready      = (tx_state_q == TX_IDLE);
    assign tx_busy       = ~tx_ready;
    assign txd           = txd_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;

endmodule
